// File: rtl/alarm_fsm.sv
// alarm_fsm
// ---------
// Home-alarm sequencing state machine. Time is measured in ticks of the
// external period timer, whose one-cycle clkFinish pulse arrives on `tick`.
// The machine runs the exit delay after arming, the entry delay after a
// delayed zone trips, and the siren timeout, after which it re-arms itself.
//
// Parameters
//   EXIT_DELAY  : ticks from an accepted arm to ARMED          (1..255)
//   ENTRY_DELAY : ticks from a delayed-zone trip to ALARM      (1..255)
//   SIREN_TIME  : ticks of siren before automatic re-arm       (1..255)
//   ENTRY_MASK  : sensor bits that are delayed (entry) zones; all other
//                 bits are instant zones
//
// Ports
//   clkSignal  in   system clock, all logic on its rising edge
//   RST        in   synchronous active-high reset
//   tick       in   one-cycle time-base pulse
//   sensor     in   [3:0] zone inputs, active-high, already synchronised
//   armReq     in   one-cycle pulse, valid code entered to arm
//   disarmReq  in   one-cycle pulse, valid code entered to disarm
//   siren      out  high in ALARM
//   buzzer     out  warning beeper, toggles per counted tick in EXIT/ENTRY
//   armedLed   out  high in every state except DISARMED
//   armFault   out  one-cycle pulse when an arm request is refused
//   tripZone   out  [3:0] latched sensor bits that caused ENTRY/ALARM
//   state      out  [2:0] DISARMED=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.

module alarm_fsm #(
    parameter int         EXIT_DELAY  = 10,
    parameter int         ENTRY_DELAY = 15,
    parameter int         SIREN_TIME  = 120,
    parameter logic [3:0] ENTRY_MASK  = 4'b0001
) (
    input  logic       clkSignal,
    input  logic       RST,
    input  logic       tick,
    input  logic [3:0] sensor,
    input  logic       armReq,
    input  logic       disarmReq,
    output logic       siren,
    output logic       buzzer,
    output logic       armedLed,
    output logic       armFault,
    output logic [3:0] tripZone,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    // A timed transition fires on the DELAY-th counted tick, i.e. when the
    // counter already holds DELAY-1 and another tick arrives.
    localparam logic [7:0] EXIT_LAST  = 8'(EXIT_DELAY - 1);
    localparam logic [7:0] ENTRY_LAST = 8'(ENTRY_DELAY - 1);
    localparam logic [7:0] SIREN_LAST = 8'(SIREN_TIME - 1);

    // Registered state
    state_t     state_q;
    logic [7:0] cnt_q;
    logic       buzzer_q;
    logic       siren_q;
    logic       armed_led_q;
    logic       arm_fault_q;
    logic [3:0] trip_zone_q;

    // Next-state values
    state_t     state_n;
    logic [7:0] cnt_n;
    logic       buzzer_n;
    logic       siren_n;
    logic       armed_led_n;
    logic       arm_fault_n;
    logic [3:0] trip_zone_n;

    // Zone classification of the current sensor vector
    logic instant_trip;
    logic entry_trip;

    assign instant_trip = |(sensor & ~ENTRY_MASK);
    assign entry_trip   = |(sensor & ENTRY_MASK);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clkSignal) begin
        if (RST) begin
            state_q     <= S_DISARMED;
            cnt_q       <= 8'd0;
            buzzer_q    <= 1'b0;
            siren_q     <= 1'b0;
            armed_led_q <= 1'b0;
            arm_fault_q <= 1'b0;
            trip_zone_q <= 4'd0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            buzzer_q    <= buzzer_n;
            siren_q     <= siren_n;
            armed_led_q <= armed_led_n;
            arm_fault_q <= arm_fault_n;
            trip_zone_q <= trip_zone_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        buzzer_n    = buzzer_q;
        arm_fault_n = 1'b0;
        trip_zone_n = trip_zone_q;

        unique case (state_q)
            S_DISARMED: begin
                // A simultaneous disarm cancels the arm request outright.
                if (armReq && !disarmReq) begin
                    if (sensor == 4'd0) begin
                        state_n     = S_EXIT;
                        trip_zone_n = 4'd0;
                    end else begin
                        arm_fault_n = 1'b1;
                    end
                end
            end

            S_EXIT: begin
                // Sensors are deliberately ignored while the user leaves.
                if (disarmReq) begin
                    state_n = S_DISARMED;
                end else if (tick && cnt_q == EXIT_LAST) begin
                    state_n = S_ARMED;
                end else if (tick) begin
                    cnt_n    = cnt_q + 8'd1;
                    buzzer_n = ~buzzer_q;
                end
            end

            S_ARMED: begin
                if (disarmReq) begin
                    state_n = S_DISARMED;
                end else if (instant_trip) begin
                    state_n     = S_ALARM;
                    trip_zone_n = sensor;
                end else if (entry_trip) begin
                    state_n     = S_ENTRY;
                    trip_zone_n = sensor;
                end
            end

            S_ENTRY: begin
                if (disarmReq) begin
                    state_n = S_DISARMED;
                end else if (instant_trip) begin
                    // Keep the original entry zone and add whatever else
                    // has come on since.
                    state_n     = S_ALARM;
                    trip_zone_n = trip_zone_q | sensor;
                end else if (tick && cnt_q == ENTRY_LAST) begin
                    state_n = S_ALARM;
                end else if (tick) begin
                    cnt_n    = cnt_q + 8'd1;
                    buzzer_n = ~buzzer_q;
                end
            end

            S_ALARM: begin
                // tripZone is kept across the re-arm so the display still
                // shows what set the alarm off.
                if (disarmReq) begin
                    state_n = S_DISARMED;
                end else if (tick && cnt_q == SIREN_LAST) begin
                    state_n = S_ARMED;
                end else if (tick) begin
                    cnt_n = cnt_q + 8'd1;
                end
            end

            default: begin
                state_n = S_DISARMED;
            end
        endcase

        // Any state change restarts the tick count; the beeper starts high
        // in the two warning states and is silent everywhere else.
        if (state_n != state_q) begin
            cnt_n    = 8'd0;
            buzzer_n = (state_n == S_EXIT) || (state_n == S_ENTRY);
        end

        siren_n     = (state_n == S_ALARM);
        armed_led_n = (state_n != S_DISARMED);
    end

    assign state    = state_q;
    assign siren    = siren_q;
    assign buzzer   = buzzer_q;
    assign armedLed = armed_led_q;
    assign armFault = arm_fault_q;
    assign tripZone = trip_zone_q;

endmodule

// File: tb/tb_alarm_fsm.sv
// Testbench for alarm_fsm with EXIT_DELAY=3, ENTRY_DELAY=2, SIREN_TIME=4,
// ENTRY_MASK=0001. Inputs change on the falling edge; a behavioural model
// follows the rising edge and a compare process checks every output on
// each falling edge, while the directed sequence also pins literal values.

module tb_alarm_fsm;

    localparam int         P_EXIT  = 3;
    localparam int         P_ENTRY = 2;
    localparam int         P_SIREN = 4;
    localparam logic [3:0] P_MASK  = 4'b0001;

    localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] sensor = 4'd0;
    logic       arm_req = 1'b0;
    logic       disarm_req = 1'b0;
    logic       siren, buzzer, armed_led, arm_fault;
    logic [3:0] trip_zone;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    alarm_fsm #(
        .EXIT_DELAY (P_EXIT),
        .ENTRY_DELAY(P_ENTRY),
        .SIREN_TIME (P_SIREN),
        .ENTRY_MASK (P_MASK)
    ) dut (
        .clkSignal(clk),
        .RST      (rst),
        .tick     (tick),
        .sensor   (sensor),
        .armReq   (arm_req),
        .disarmReq(disarm_req),
        .siren    (siren),
        .buzzer   (buzzer),
        .armedLed (armed_led),
        .armFault (arm_fault),
        .tripZone (trip_zone),
        .state    (state)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: mode, ticks elapsed in the mode, latched zones.
    // The beeper is simply "even number of ticks elapsed" in warning modes.
    // ------------------------------------------------------------------
    int         m_mode  = M_DIS;
    int         m_ticks = 0;
    logic [3:0] m_trip  = 4'd0;
    bit         m_fault = 1'b0;

    function automatic int delay_of(input int mode);
        case (mode)
            M_EXIT:  return P_EXIT;
            M_ENTRY: return P_ENTRY;
            M_ALARM: return P_SIREN;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        int  nxt;
        bit  instant, entry, expired;
        m_fault = 1'b0;
        if (rst) begin
            m_mode  = M_DIS;
            m_ticks = 0;
            m_trip  = 4'd0;
        end else begin
            nxt     = m_mode;
            instant = (sensor & ~P_MASK) != 4'd0;
            entry   = (sensor & P_MASK) != 4'd0;
            expired = tick && (m_ticks + 1 == delay_of(m_mode));
            if (m_mode == M_DIS) begin
                if (arm_req && !disarm_req) begin
                    if (sensor == 4'd0) begin
                        nxt    = M_EXIT;
                        m_trip = 4'd0;
                    end else begin
                        m_fault = 1'b1;
                    end
                end
            end else if (disarm_req) begin
                nxt = M_DIS;
            end else if (m_mode == M_ARMED) begin
                if (instant) begin
                    nxt = M_ALARM; m_trip = sensor;
                end else if (entry) begin
                    nxt = M_ENTRY; m_trip = sensor;
                end
            end else if (m_mode == M_ENTRY && instant) begin
                nxt    = M_ALARM;
                m_trip = m_trip | sensor;
            end else if (expired) begin
                nxt = (m_mode == M_ENTRY) ? M_ALARM : M_ARMED;
            end else if (tick) begin
                m_ticks++;
            end
            if (nxt != m_mode) begin
                m_mode  = nxt;
                m_ticks = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("model.state",    8'(state),     8'(m_mode));
            chk("model.siren",    8'(siren),     8'(m_mode == M_ALARM));
            chk("model.armedLed", 8'(armed_led), 8'(m_mode != M_DIS));
            chk("model.buzzer",   8'(buzzer),
                8'((m_mode == M_EXIT || m_mode == M_ENTRY) && (m_ticks % 2 == 0)));
            chk("model.armFault", 8'(arm_fault), 8'(m_fault));
            chk("model.tripZone", 8'(trip_zone), 8'(m_trip));
        end
    end

    // One clock with the given inputs; returns on the following falling edge.
    task automatic drive(input logic t, input logic [3:0] s, input logic a,
                         input logic d, input logic r);
        tick = t; sensor = s; arm_req = a; disarm_req = d; rst = r;
        @(negedge clk);
        tick = 1'b0; sensor = 4'd0; arm_req = 1'b0; disarm_req = 1'b0; rst = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tk();
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_en = 1'b1;
        chk("reset.state",    8'(state),     8'd0);
        chk("reset.outs",     8'({siren, buzzer, armed_led, arm_fault}), 8'd0);
        chk("reset.tripZone", 8'(trip_zone), 8'd0);

        // Arm refused with an instant zone open
        drive(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        chk("refuse.armFault", 8'(arm_fault), 8'd1);
        chk("refuse.state",    8'(state),     8'd0);
        chk("refuse.tripZone", 8'(trip_zone), 8'd0);
        idle();
        chk("refuse.armFault_drop", 8'(arm_fault), 8'd0);

        // Exit delay
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("exit.state",    8'(state),     8'd1);
        chk("exit.buzzer",   8'(buzzer),    8'd1);
        chk("exit.armedLed", 8'(armed_led), 8'd1);
        tk();
        chk("exit.buzzer_t1", 8'(buzzer), 8'd0);
        idle();
        chk("exit.hold_state", 8'(state), 8'd1);
        tk();
        chk("exit.buzzer_t2", 8'(buzzer), 8'd1);
        tk();
        chk("exit.armed",       8'(state),  8'd2);
        chk("exit.buzzer_arm",  8'(buzzer), 8'd0);

        // Entry delay expires, siren times out and re-arms
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        chk("entry.state",    8'(state),     8'd3);
        chk("entry.tripZone", 8'(trip_zone), 8'd1);
        tk();
        chk("entry.hold", 8'(state), 8'd3);
        tk();
        chk("entry.alarm", 8'(state), 8'd4);
        chk("entry.siren", 8'(siren), 8'd1);
        tk(); tk(); tk();
        chk("siren.hold", 8'(state), 8'd4);
        tk();
        chk("siren.rearm",    8'(state),     8'd2);
        chk("siren.off",      8'(siren),     8'd0);
        chk("siren.tripZone", 8'(trip_zone), 8'd1);

        // Instant zone while in ENTRY, then disarm
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        chk("inst.entry", 8'(state), 8'd3);
        drive(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        chk("inst.alarm",    8'(state),     8'd4);
        chk("inst.tripZone", 8'(trip_zone), 8'd3);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("disarm.state",    8'(state),     8'd0);
        chk("disarm.siren",    8'(siren),     8'd0);
        chk("disarm.armedLed", 8'(armed_led), 8'd0);
        chk("disarm.tripZone", 8'(trip_zone), 8'd3);

        // Simultaneous tick+disarm at the end of EXIT, then arm+disarm
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("sim.exit",     8'(state),     8'd1);
        chk("sim.tripClr",  8'(trip_zone), 8'd0);
        tk(); tk();
        drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("sim.tick_disarm", 8'(state), 8'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("sim.arm_disarm_state", 8'(state),     8'd0);
        chk("sim.arm_disarm_fault", 8'(arm_fault), 8'd0);

        // Mid-alarm reset, then a clean re-arm
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tk(); tk(); tk();
        drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("rst.alarm",    8'(state),     8'd4);
        chk("rst.tripZone", 8'(trip_zone), 8'd2);
        tk(); tk();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("rst.state",    8'(state),     8'd0);
        chk("rst.outs",     8'({siren, buzzer, armed_led, arm_fault}), 8'd0);
        chk("rst.tripZone", 8'(trip_zone), 8'd0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tk(); tk();
        chk("rearm.not_yet", 8'(state), 8'd1);
        tk();
        chk("rearm.armed", 8'(state), 8'd2);

        // A zone still open when the siren times out trips again
        drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < P_SIREN; i++) drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("retrip.armed", 8'(state), 8'd2);
        drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("retrip.alarm", 8'(state), 8'd4);
        idle();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
